// File: rtl/qam_symbol_error_counter_pkg.sv
// rtl/qam_symbol_error_counter_pkg.sv - shared encodings and helpers for the QAM symbol error counter
package qam_symbol_error_counter_pkg;

  localparam int SYM_W_DEF = 5;

  localparam logic [2:0] MOD_QAM32 = 3'b000;
  localparam logic [2:0] MOD_QAM16 = 3'b001;
  localparam logic [2:0] MOD_QAM8  = 3'b010;
  localparam logic [2:0] MOD_QAM4  = 3'b011;
  localparam logic [2:0] MOD_BPSK  = 3'b100;

  // Active bits per symbol; unknown orders fall back to the full 32-QAM width.
  function automatic logic [SYM_W_DEF-1:0] orderMask(input logic [2:0] order);
    case (order)
      MOD_QAM16: return 5'b01111;
      MOD_QAM8:  return 5'b00111;
      MOD_QAM4:  return 5'b00011;
      MOD_BPSK:  return 5'b00001;
      default:   return 5'b11111;
    endcase
  endfunction

  function automatic logic [2:0] popCount(input logic [SYM_W_DEF-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < SYM_W_DEF; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/qam_symbol_error_counter_ref_fifo.sv
// rtl/qam_symbol_error_counter_ref_fifo.sv - reference symbol FIFO with registered read and flush
module qam_ref_fifo #(
  parameter int DEPTH = 512,
  parameter int W     = 5
) (
  input  logic         Clk,
  input  logic         RstN,
  input  logic         Flush,
  input  logic         PushEn,
  input  logic [W-1:0] PushData,
  input  logic         PopEn,
  output logic [W-1:0] PopData,
  output logic         Full,
  output logic         Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          doPush;
  logic          doPop;

  assign Full   = (count == (AW+1)'(DEPTH));
  assign Empty  = (count == '0);
  assign doPush = PushEn && !Full;
  assign doPop  = PopEn && !Empty;

  always_ff @(posedge Clk) begin
    if (doPush && !Flush) mem[wrPtr] <= PushData;
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      PopData <= '0;
    end else if (Flush) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      PopData <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) begin
        rdPtr   <= rdPtr + 1'b1;
        PopData <= mem[rdPtr];
      end
      count <= count + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
    end
  end

endmodule

// File: rtl/qam_symbol_error_counter.sv
// rtl/qam_symbol_error_counter.sv - compares demodulated QAM symbols against buffered reference symbols
module qam_symbol_error_counter
  import qam_symbol_error_counter_pkg::*;
#(
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 512,
  parameter int SYM_W      = SYM_W_DEF
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Start,
  input  logic [2:0]       ModulationOrder,
  input  logic             TxSymValid,
  input  logic [SYM_W-1:0] TxSym,
  input  logic             RxSymValid,
  input  logic [SYM_W-1:0] RxSym,
  output logic             Busy,
  output logic             FrameDoneValid,
  output logic [8:0]       FrameSymErrors,
  output logic [11:0]      FrameBitErrors,
  output logic [15:0]      TotalFrames,
  output logic [31:0]      TotalBitErrors,
  output logic             Overflow,
  output logic             Underflow
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic             state;
  logic [SYM_W-1:0] symMask;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [SYM_W-1:0] fifoHead;
  logic             accept;
  logic             pushReq;
  logic             popReq;

  // Pipeline: pop -> xor -> accumulate -> frame result
  logic             popQ;
  logic [SYM_W-1:0] rxQ;
  logic             xValid;
  logic             xLast;
  logic [SYM_W-1:0] xQ;
  logic [8:0]       symCnt;
  logic             doneQ;
  logic [8:0]       accSym;
  logic [11:0]      accBit;
  logic [2:0]       xBits;
  logic [32:0]      totalSum;

  assign Busy     = (state == ST_RUN);
  assign accept   = Busy && !Start;
  assign pushReq  = accept && TxSymValid;
  assign popReq   = accept && RxSymValid && !fifoEmpty;
  assign xBits    = popCount(xQ);
  assign totalSum = {1'b0, TotalBitErrors} + {30'b0, xBits};

  qam_ref_fifo #(.DEPTH(FIFO_DEPTH), .W(SYM_W)) uFifo (
    .Clk      (Clk),
    .RstN     (RstN),
    .Flush    (Start),
    .PushEn   (pushReq),
    .PushData (TxSym),
    .PopEn    (popReq),
    .PopData  (fifoHead),
    .Full     (fifoFull),
    .Empty    (fifoEmpty)
  );

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state          <= ST_IDLE;
      symMask        <= '0;
      popQ           <= 1'b0;
      rxQ            <= '0;
      xValid         <= 1'b0;
      xLast          <= 1'b0;
      xQ             <= '0;
      symCnt         <= '0;
      doneQ          <= 1'b0;
      accSym         <= '0;
      accBit         <= '0;
      FrameDoneValid <= 1'b0;
      FrameSymErrors <= '0;
      FrameBitErrors <= '0;
      TotalFrames    <= '0;
      TotalBitErrors <= '0;
      Overflow       <= 1'b0;
      Underflow      <= 1'b0;
    end else if (Start) begin
      state          <= ST_RUN;
      symMask        <= orderMask(ModulationOrder);
      popQ           <= 1'b0;
      rxQ            <= '0;
      xValid         <= 1'b0;
      xLast          <= 1'b0;
      xQ             <= '0;
      symCnt         <= '0;
      doneQ          <= 1'b0;
      accSym         <= '0;
      accBit         <= '0;
      FrameDoneValid <= 1'b0;
      FrameSymErrors <= '0;
      FrameBitErrors <= '0;
      TotalFrames    <= '0;
      TotalBitErrors <= '0;
      Overflow       <= 1'b0;
      Underflow      <= 1'b0;
    end else if (state == ST_RUN) begin
      if (TxSymValid && fifoFull) Overflow <= 1'b1;
      if (RxSymValid && fifoEmpty) Underflow <= 1'b1;

      popQ <= popReq;
      if (popReq) rxQ <= RxSym;

      xValid <= popQ;
      if (popQ) begin
        xQ <= (fifoHead ^ rxQ) & symMask;
        if (symCnt == 9'(FRAME_LEN - 1)) begin
          symCnt <= '0;
          xLast  <= 1'b1;
        end else begin
          symCnt <= symCnt + 1'b1;
          xLast  <= 1'b0;
        end
      end

      // A finished frame restarts the accumulators in the same cycle the next symbol lands.
      accSym <= (doneQ ? 9'd0 : accSym) + {8'b0, xValid && (xQ != '0)};
      accBit <= (doneQ ? 12'd0 : accBit) + (xValid ? {9'b0, xBits} : 12'd0);
      doneQ  <= xValid && xLast;
      if (xValid) TotalBitErrors <= totalSum[32] ? 32'hFFFF_FFFF : totalSum[31:0];

      FrameDoneValid <= doneQ;
      if (doneQ) begin
        FrameSymErrors <= accSym;
        FrameBitErrors <= accBit;
        TotalFrames    <= TotalFrames + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qam_symbol_error_counter.sv
// tb/tb_qam_symbol_error_counter.sv - directed scoreboard bench for qam_symbol_error_counter
module tb_qam_symbol_error_counter;

  localparam int FRAME_LEN = 256;

  typedef struct {
    int     sym;
    int     bits;
    longint cyc;
  } frame_exp_t;

  logic        Clk = 1'b0;
  logic        RstN = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  ModulationOrder = 3'd0;
  logic        TxSymValid = 1'b0;
  logic [4:0]  TxSym = '0;
  logic        RxSymValid = 1'b0;
  logic [4:0]  RxSym = '0;
  logic        Busy;
  logic        FrameDoneValid;
  logic [8:0]  FrameSymErrors;
  logic [11:0] FrameBitErrors;
  logic [15:0] TotalFrames;
  logic [31:0] TotalBitErrors;
  logic        Overflow;
  logic        Underflow;

  int         nAssert = 0;
  int         nFail = 0;
  longint     cyc = 0;
  frame_exp_t sbq[$];
  logic [4:0] txArr [0:599];
  logic [4:0] errArr [0:599];
  logic [2:0] curOrder = 3'd0;
  int         modelSym, modelBit, symInFrame, expFrames;
  longint     expTotalBits;

  qam_symbol_error_counter #(.FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(512), .SYM_W(5)) dut (
    .Clk             (Clk),
    .RstN            (RstN),
    .Start           (Start),
    .ModulationOrder (ModulationOrder),
    .TxSymValid      (TxSymValid),
    .TxSym           (TxSym),
    .RxSymValid      (RxSymValid),
    .RxSym           (RxSym),
    .Busy            (Busy),
    .FrameDoneValid  (FrameDoneValid),
    .FrameSymErrors  (FrameSymErrors),
    .FrameBitErrors  (FrameBitErrors),
    .TotalFrames     (TotalFrames),
    .TotalBitErrors  (TotalBitErrors),
    .Overflow        (Overflow),
    .Underflow       (Underflow)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] tbMask(input logic [2:0] ord);
    case (ord)
      3'd1:    return 5'h0F;
      3'd2:    return 5'h07;
      3'd3:    return 5'h03;
      3'd4:    return 5'h01;
      default: return 5'h1F;
    endcase
  endfunction

  always @(negedge Clk) begin
    if (RstN && FrameDoneValid) begin
      if (sbq.size() == 0) begin
        check("spurious_frame_done", 64'd1, 64'd0);
      end else begin
        frame_exp_t e;
        e = sbq.pop_front();
        check("frame_done_cycle", 64'(cyc), 64'(e.cyc));
        check("frame_sym_errors", 64'(FrameSymErrors), 64'(e.sym));
        check("frame_bit_errors", 64'(FrameBitErrors), 64'(e.bits));
      end
    end
  end

  task automatic modelPop(input int j);
    logic [4:0] x;
    x = errArr[j] & tbMask(curOrder);
    if (x != 0) modelSym++;
    modelBit += $countones(x);
    expTotalBits += $countones(x);
    symInFrame++;
    if (symInFrame == FRAME_LEN) begin
      sbq.push_back('{sym: modelSym, bits: modelBit, cyc: cyc + 3});
      expFrames++;
      modelSym = 0;
      modelBit = 0;
      symInFrame = 0;
    end
  endtask

  task automatic runSyms(input int nTx, input int nRx, input int dly);
    int last;
    last = (nTx > dly + nRx) ? nTx : dly + nRx;
    for (int t = 0; t < last; t++) begin
      logic rxOn;
      rxOn = (t >= dly) && (t < dly + nRx);
      TxSymValid = (t < nTx);
      TxSym = (t < nTx) ? txArr[t] : 5'd0;
      RxSymValid = rxOn;
      RxSym = rxOn ? (txArr[t-dly] ^ errArr[t-dly]) : 5'd0;
      @(posedge Clk); #1;
      if (rxOn) modelPop(t - dly);
    end
    TxSymValid = 1'b0;
    RxSymValid = 1'b0;
  endtask

  task automatic doStart(input logic [2:0] ord);
    Start = 1'b1;
    ModulationOrder = ord;
    @(posedge Clk); #1;
    Start = 1'b0;
    curOrder = ord;
    modelSym = 0;
    modelBit = 0;
    symInFrame = 0;
    expFrames = 0;
    expTotalBits = 0;
    sbq.delete();
  endtask

  task automatic rxPulse();
    RxSymValid = 1'b1;
    RxSym = 5'd3;
    @(posedge Clk); #1;
    RxSymValid = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (8) @(posedge Clk);
    #1;
    check({tag, "_frames_pending"}, 64'(sbq.size()), 64'd0);
    check({tag, "_total_frames"}, 64'(TotalFrames), 64'(expFrames));
    check({tag, "_total_bits"}, 64'(TotalBitErrors), 64'(expTotalBits));
    sbq.delete();
  endtask

  function automatic void fillSeq(input int n);
    for (int i = 0; i < n; i++) begin
      txArr[i] = 5'(i % 32);
      errArr[i] = 5'd0;
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1 RstN = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("idle_busy", 64'(Busy), 64'd0);
    check("idle_total_frames", 64'(TotalFrames), 64'd0);

    // Error-free 32-QAM frame with a 40-cycle Tx/Rx latency
    doStart(3'd0);
    check("run_busy", 64'(Busy), 64'd1);
    fillSeq(256);
    runSyms(256, 256, 40);
    drain("clean");
    check("clean_sym", 64'(FrameSymErrors), 64'd0);
    check("clean_bits", 64'(FrameBitErrors), 64'd0);
    check("clean_frames", 64'(TotalFrames), 64'd1);

    // Injected errors
    doStart(3'd0);
    fillSeq(256);
    errArr[0] = 5'h01;
    errArr[10] = 5'h01;
    errArr[20] = 5'h1F;
    runSyms(256, 256, 40);
    drain("inject");
    check("inject_sym", 64'(FrameSymErrors), 64'd3);
    check("inject_bits", 64'(FrameBitErrors), 64'd7);
    check("inject_total_bits", 64'(TotalBitErrors), 64'd7);

    // Asynchronous reset mid-run
    #3 RstN = 1'b0;
    #1;
    check("rst_outputs", {Busy, FrameDoneValid, FrameSymErrors, FrameBitErrors, TotalFrames,
                          TotalBitErrors, Overflow, Underflow}, 64'd0);
    @(posedge Clk); @(posedge Clk);
    #1 RstN = 1'b1;
    rxPulse();
    repeat (2) @(posedge Clk);
    #1;
    check("post_rst_busy", 64'(Busy), 64'd0);
    check("idle_rx_ignored", 64'(Underflow), 64'd0);

    // 4-QAM: differences confined to bits 4:2 are masked out
    doStart(3'd3);
    for (int i = 0; i < 256; i++) begin
      txArr[i] = 5'($urandom_range(0, 31));
      errArr[i] = {3'($urandom_range(1, 7)), 2'b00};
    end
    runSyms(256, 256, 10);
    drain("mask");
    check("mask_sym", 64'(FrameSymErrors), 64'd0);
    check("mask_bits", 64'(FrameBitErrors), 64'd0);

    // Underflow on an empty FIFO leaves the symbol count alone
    doStart(3'd0);
    rxPulse();
    #1;
    check("uf_flag", 64'(Underflow), 64'd1);
    check("uf_no_overflow", 64'(Overflow), 64'd0);
    fillSeq(256);
    runSyms(256, 256, 5);
    drain("uf");

    // Overflow: 513 pushes keep 512 entries, which drain as two clean frames
    doStart(3'd0);
    fillSeq(513);
    runSyms(513, 0, 0);
    check("of_flag", 64'(Overflow), 64'd1);
    check("of_no_underflow", 64'(Underflow), 64'd0);
    runSyms(0, 512, 0);
    drain("of");
    check("of_frames", 64'(TotalFrames), 64'd2);
    check("of_full_drain_no_uf", 64'(Underflow), 64'd0);
    rxPulse();
    check("of_513th_pop_uf", 64'(Underflow), 64'd1);

    // Mid-frame Start discards the partial frame and clears sticky flags
    doStart(3'd0);
    rxPulse();
    for (int i = 0; i < 100; i++) begin
      txArr[i] = 5'($urandom_range(0, 31));
      errArr[i] = 5'($urandom_range(1, 31));
    end
    runSyms(100, 100, 3);
    check("mid_uf_before", 64'(Underflow), 64'd1);
    doStart(3'd0);
    check("mid_uf_cleared", 64'(Underflow), 64'd0);
    check("mid_of_cleared", 64'(Overflow), 64'd0);
    fillSeq(256);
    runSyms(256, 256, 20);
    drain("mid");
    check("mid_sym", 64'(FrameSymErrors), 64'd0);
    check("mid_frames", 64'(TotalFrames), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/qam_symbol_error_counter.md
Name: qam_symbol_error_counter

Overview:
- Receive-side checker for the OTFS/QAM chain.
- Captures each reference symbol index on the transmit side as it enters the QAM modulator, and buffers it in a FIFO across the OTFS Tx/Rx latency.
- Pops one reference entry per QAM demodulator output and compares the two.
- Reports per-frame symbol/bit error counts plus cumulative totals for BER measurement, on board or in simulation.

Parameters:
FRAME_LEN, 256, demodulated symbols per frame (1..256)
FIFO_DEPTH, 512, reference FIFO entries (power of 2, >= FRAME_LEN)
SYM_W, 5, symbol index width (32-QAM maximum)

Ports:
Clk  in  1  system clock, rising edge
RstN  in  1  asynchronous active-low reset
Start  in  1  one-cycle pulse; clears all state, samples ModulationOrder, enters RUN
ModulationOrder  in  3  000=32-QAM, 001=16-QAM, 010=8-QAM, 011=4-QAM, 100=BPSK; others treated as 32-QAM
TxSymValid  in  1  reference symbol strobe
TxSym  in  SYM_W  reference symbol index
RxSymValid  in  1  demodulated symbol strobe (QAMDemodDataValid)
RxSym  in  SYM_W  demodulated symbol (QAMDemodData)
Busy  out  1  high in RUN
FrameDoneValid  out  1  one-cycle pulse, frame result valid
FrameSymErrors  out  9  symbol errors in last completed frame
FrameBitErrors  out  12  bit errors in last completed frame
TotalFrames  out  16  completed frames since Start, wraps
TotalBitErrors  out  32  cumulative bit errors, saturates at 2^32-1
Overflow  out  1  sticky: push attempted with FIFO full
Underflow  out  1  sticky: RxSymValid with FIFO empty

Behaviour:
- Reset (RstN low, asynchronous): all outputs 0, state IDLE, FIFO empty, all counters 0.
- States:
  - IDLE: Tx/Rx strobes ignored. Start -> RUN.
  - RUN: Start -> flush FIFO, clear all counters and sticky flags, re-sample ModulationOrder; stay in RUN.
  - No other exit from RUN except reset.
- Active bit mask K from the sampled order: 5, 4, 3, 2, 1 bits (LSBs).
- Push: in RUN, TxSymValid pushes TxSym.
  - FIFO full: push dropped, Overflow set.
- Pop: in RUN, RxSymValid pops.
  - FIFO empty, including a same-cycle push into an empty FIFO (no bypass): Rx symbol discarded, not counted, Underflow set.
- Simultaneous push and pop with FIFO neither empty nor full: both occur, occupancy unchanged.
- Pipeline, for a pop accepted at edge k:
  - Edge k+1: XOR of masked RxSym and FIFO head registered; symbol counter incremented.
  - Edge k+2: popcount(XOR) added to frame bit counter; frame symbol counter +1 if XOR nonzero; TotalBitErrors updated (saturating).
- Frame end: when the accepted symbol is number FRAME_LEN of the frame:
  - FrameSymErrors/FrameBitErrors load the final sums (including that symbol) at edge k+3.
  - FrameDoneValid is high for the cycle following edge k+3.
  - TotalFrames increments at the same edge.
  - Frame accumulators restart at 0 with no lost symbols; back-to-back frames are supported at one symbol per clock.
- FrameSymErrors/FrameBitErrors hold until the next frame end or Start.
- Start in the same cycle as an Rx/Tx strobe: the strobe is ignored; the flush wins.
- In-flight pipeline results are discarded on Start.
- Widths: maximum FrameBitErrors is 256*5 = 1280 (fits in 12 bits); FrameSymErrors maximum is 256.

Decomposition:
- Shared package/header: ModulationOrder encodings, order-to-K mask function, popcount function for SYM_W bits.
- One sub-module: qam_ref_fifo — synchronous single-clock FIFO with registered read, full/empty flags, synchronous flush input, asynchronous active-low reset.

Test Plan:
1. Reset check: assert RstN low mid-simulation -> every output 0 immediately without a clock edge; after release, Busy stays 0 until Start.
2. Error-free frame:
   - Stimulus: Start with order 000; push 256 symbols 0..31 repeating; pop identical symbols with a 40-cycle delay.
   - Required response: exactly one FrameDoneValid pulse, 3 cycles after the last pop; FrameSymErrors 0; FrameBitErrors 0; TotalFrames 1.
3. Injected errors, 32-QAM:
   - Stimulus: flip bit0 on symbols 0 and 10; flip all 5 bits on symbol 20.
   - Required response: FrameSymErrors 3; FrameBitErrors 7; TotalBitErrors 7.
4. Mask check, 4-QAM:
   - Stimulus: order 011; Rx differs from Tx only in bits 4:2 on every symbol.
   - Required response: FrameSymErrors 0; FrameBitErrors 0.
5. Underflow and overflow:
   - Rx pulse before any push -> Underflow 1; symbol count unchanged.
   - 513 pushes without pops -> Overflow 1; occupancy 512.
6. Mid-frame Start:
   - Stimulus: 100 symbols pushed/popped with errors, then Start, then a full clean frame.
   - Required response: FrameSymErrors 0; TotalFrames 1; sticky flags cleared.
